// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate backed by a little-endian, byte-lane SRAM.
// OKAY transfers take WAIT_STATES+1 data-phase cycles; errors use the two-cycle
// ERROR response. Read data is driven only in the final cycle of a read.
module ahb_sram_slave #(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [6:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned MEM_WORDS = (MEM_BYTES > 4) ? MEM_BYTES / 4 : 1;
  localparam int unsigned IDX_W     = (MEM_BYTES > 4) ? $clog2(MEM_BYTES) - 2 : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state_reg;
  logic [3:0]         wait_cnt_reg;
  logic               write_reg;
  logic [3:0]         be_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               hreadyout_reg;
  logic               hresp_reg;

  logic [31:0]        offset;
  logic               accept;
  logic               size_err;
  logic               align_err;
  logic               range_err;
  logic               xfer_err;
  logic [3:0]         be_next;
  logic               mem_we;
  logic [31:0]        rd_word;

  // Burst type, protection, lock and the BUSY/SEQ distinction do not change the response.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address-phase decode. The hreadyout_reg term keeps WAIT/ERR1 from sampling
  // a new address even if the bus-level HREADY is not wired back correctly.
  assign offset    = HADDR - BASE_ADDR;
  assign accept    = HSEL & HREADY & HTRANS[1] & hreadyout_reg;
  assign size_err  = (HSIZE > 3'd2);
  assign range_err = (offset >= MEM_BYTES);
  assign xfer_err  = size_err | align_err | range_err;

  // Alignment check and byte-lane enables for the sampled transfer size.
  always_comb begin
    align_err = 1'b0;
    be_next   = 4'b0000;
    case (HSIZE)
      3'd0: be_next = 4'b0001 << HADDR[1:0];
      3'd1: begin
        align_err = HADDR[0];
        be_next   = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        align_err = (HADDR[1:0] != 2'b00);
        be_next   = 4'b1111;
      end
      default: be_next = 4'b0000;
    endcase
  end

  // Transfer FSM with registered HREADYOUT/HRESP and latched data-phase controls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 4'd0;
      write_reg     <= 1'b0;
      be_reg        <= 4'b0000;
      idx_reg       <= '0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (wait_cnt_reg <= 4'd1) begin
            state_reg     <= ST_DATA;
            hreadyout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new address phase may land here.
          if (accept) begin
            write_reg <= HWRITE;
            be_reg    <= be_next;
            idx_reg   <= offset[IDX_W+1:2];
            if (xfer_err) begin
              state_reg     <= ST_ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_reg     <= ST_WAIT;
              wait_cnt_reg  <= 4'(WAIT_STATES);
              hreadyout_reg <= 1'b0;
              hresp_reg     <= 1'b0;
            end else begin
              state_reg     <= ST_DATA;
              hreadyout_reg <= 1'b1;
              hresp_reg     <= 1'b0;
            end
          end else begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Writes commit on the edge that ends the DATA cycle; errored writes never reach DATA.
  assign mem_we = (state_reg == ST_DATA) & write_reg;

  // One byte-wide array per lane so each lane has a single writer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [MEM_WORDS];

      // Commit this lane's byte when the latched transfer enables it.
      always_ff @(posedge HCLK) begin
        if (mem_we && be_reg[gi]) begin
          mem[idx_reg] <= HWDATA[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[idx_reg];
    end
  endgenerate

  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;
  assign HRDATA    = ((state_reg == ST_DATA) && !write_reg) ? rd_word : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB-Lite traffic against three instances
// (0, 3 and 5 wait states). The driver pushes the expected response of each
// accepted transfer; a monitor pops and compares when the data phase ends.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  typedef struct {
    int          id;
    bit          err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             hsel_bus;
  logic [31:0]      haddr;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [6:0]       hprot;
  logic [1:0]       htrans;
  logic             hmastlock;
  logic [31:0]      hwdata;
  logic [2:0]       hreadyout;
  logic [2:0]       hresp;
  logic [2:0][31:0] hrdata;
  int               cur;

  int   n_vec;
  int   n_bad;
  int   vec_id;
  exp_t expq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_bus && (cur == 0)), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_bus && (cur == 1)), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  ahb_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(5), .BASE_ADDR(32'h0)) u_ws5 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_bus && (cur == 2)), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hreadyout[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2])
  );

  function automatic int ws_of(input int idx);
    case (idx)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endfunction

  // One address phase; returns 1ns after the edge that sampled it, with HWDATA
  // now carrying this transfer's write data for its data phase.
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit err, input logic [31:0] rd);
    exp_t e;
    bit   rdy;
    int   guard;
    hsel_bus = sel;
    htrans   = trans;
    hwrite   = wr;
    hsize    = size;
    haddr    = addr;
    if (sel && trans[1]) begin
      e.id    = vec_id;
      e.err   = err;
      e.waits = err ? 1 : ws_of(cur);
      e.rdata = rd;
      vec_id++;
      expq.push_back(e);
    end
    guard = 0;
    do begin
      @(negedge clk);
      rdy = hreadyout[cur];
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) begin
      n_vec++;
      n_bad++;
      $display("FAIL addr_phase_timeout: HREADYOUT stayed 0, required 1 within 50 cycles");
    end
    if (wr) hwdata = wdata;
    hsel_bus = 1'b0;
    htrans   = T_IDLE;
  endtask

  task automatic wr_x(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
    xfer(1'b1, T_NONSEQ, 1'b1, size, addr, data, 1'b0, 32'h0);
  endtask

  task automatic rd_x(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] expv);
    xfer(1'b1, T_NONSEQ, 1'b0, size, addr, 32'h0, 1'b0, expv);
  endtask

  task automatic err_x(input logic wr, input logic [2:0] size, input logic [31:0] addr);
    xfer(1'b1, T_NONSEQ, wr, size, addr, 32'hFFFF_FFFF, 1'b1, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples mid-cycle, scores each finished data phase, checks idle cycles.
  initial begin : monitor
    bit   pend;
    bit   saw_err;
    int   wcnt;
    exp_t e;
    pend    = 1'b0;
    saw_err = 1'b0;
    wcnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (!hreadyout[cur]) begin
            wcnt++;
            if (hresp[cur]) saw_err = 1'b1;
            check("wait_cycle_hrdata", hrdata[cur], 32'h0);
            if (wcnt > 40) begin
              n_vec++;
              n_bad++;
              $display("FAIL data_phase_timeout: %0d low cycles, required completion", wcnt);
              pend = 1'b0;
            end
          end else begin
            if (expq.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_response: data phase ended, required no transfer");
            end else begin
              e = expq.pop_front();
              check($sformatf("vec%0d resp", e.id), {30'h0, saw_err, hresp[cur]},
                    e.err ? 32'h3 : 32'h0);
              check($sformatf("vec%0d waits", e.id), wcnt, e.waits);
              check($sformatf("vec%0d hrdata", e.id), hrdata[cur], e.rdata);
            end
            pend = 1'b0;
          end
        end else begin
          check("idle_hreadyout", {31'h0, hreadyout[cur]}, 32'h1);
          check("idle_hresp", {31'h0, hresp[cur]}, 32'h0);
          check("idle_hrdata", hrdata[cur], 32'h0);
        end
        if (hsel_bus && hreadyout[cur] && htrans[1]) begin
          pend    = 1'b1;
          wcnt    = 0;
          saw_err = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin : stimulus
    n_vec     = 0;
    n_bad     = 0;
    vec_id    = 0;
    cur       = 0;
    rst_n     = 1'b0;
    hsel_bus  = 1'b0;
    haddr     = 32'h0;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    hburst    = 3'd0;
    hprot     = 7'h0;
    htrans    = T_IDLE;
    hmastlock = 1'b0;
    hwdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d hreadyout", i), {31'h0, hreadyout[i]}, 32'h1);
      check($sformatf("reset%0d hresp", i), {31'h0, hresp[i]}, 32'h0);
      check($sformatf("reset%0d hrdata", i), hrdata[i], 32'h0);
    end
    rst_n = 1'b1;
    idle(2);

    // Zero wait states: back-to-back write then read of the same word.
    cur = 0;
    wr_x(3'd2, 32'h10, 32'hDEAD_BEEF);
    rd_x(3'd2, 32'h10, 32'hDEAD_BEEF);
    idle(2);

    // Byte lanes, then a half-word overwrite of the upper half.
    wr_x(3'd0, 32'h20, 32'h0000_0011);
    wr_x(3'd0, 32'h21, 32'h0000_2200);
    wr_x(3'd0, 32'h22, 32'h0033_0000);
    wr_x(3'd0, 32'h23, 32'h4400_0000);
    rd_x(3'd2, 32'h20, 32'h4433_2211);
    wr_x(3'd1, 32'h22, 32'hABCD_0000);
    rd_x(3'd2, 32'h20, 32'hABCD_2211);
    idle(2);

    // Error responses; the errored write to 0x2 must leave word 0 intact.
    wr_x(3'd2, 32'h0, 32'h1234_5678);
    err_x(1'b1, 3'd2, 32'h2);
    err_x(1'b0, 3'd2, 32'h1000);
    err_x(1'b0, 3'd3, 32'h0);
    err_x(1'b1, 3'd1, 32'h1);
    rd_x(3'd2, 32'h0, 32'h1234_5678);
    idle(2);

    // Four-beat read burst with BUSY beats between.
    wr_x(3'd2, 32'h40, 32'hCAFE_0001);
    wr_x(3'd2, 32'h44, 32'hCAFE_0002);
    wr_x(3'd2, 32'h48, 32'hCAFE_0003);
    wr_x(3'd2, 32'h4C, 32'hCAFE_0004);
    idle(1);
    xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'hCAFE_0001);
    xfer(1'b1, T_BUSY,   1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'h0);
    xfer(1'b1, T_SEQ,    1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'hCAFE_0002);
    xfer(1'b1, T_BUSY,   1'b0, 3'd2, 32'h48, 32'h0, 1'b0, 32'h0);
    xfer(1'b1, T_SEQ,    1'b0, 3'd2, 32'h48, 32'h0, 1'b0, 32'hCAFE_0003);
    xfer(1'b1, T_SEQ,    1'b0, 3'd2, 32'h4C, 32'h0, 1'b0, 32'hCAFE_0004);
    idle(2);

    // Unselected traffic must neither respond nor write.
    xfer(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0000_0000, 1'b0, 32'h0);
    idle(1);
    rd_x(3'd2, 32'h10, 32'hDEAD_BEEF);
    idle(2);

    // Three wait states: write, read, back-to-back reads, and an error.
    cur = 1;
    wr_x(3'd2, 32'h80, 32'h5A5A_5A5A);
    rd_x(3'd2, 32'h80, 32'h5A5A_5A5A);
    wr_x(3'd0, 32'h81, 32'h0000_C300);
    rd_x(3'd2, 32'h80, 32'h5A5A_C35A);
    err_x(1'b0, 3'd2, 32'h3);
    rd_x(3'd1, 32'h82, 32'h5A5A_C35A);
    idle(6);

    // Five wait states: reset during the WAIT of a write drops it.
    cur = 2;
    wr_x(3'd2, 32'h100, 32'h0102_0304);
    idle(8);
    xfer(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h100, 32'hFFFF_FFFF, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_reset hreadyout", {31'h0, hreadyout[2]}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_reset hreadyout", {31'h0, hreadyout[2]}, 32'h1);
    check("async_reset hresp", {31'h0, hresp[2]}, 32'h0);
    check("async_reset hrdata", hrdata[2], 32'h0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    rd_x(3'd2, 32'h100, 32'h0102_0304);
    idle(8);

    check("queue_drained", expq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
